// File: rtl/stack_sequencer.sv
// stack_sequencer
// Command front end for the bit-lane stack. Takes one opcode at a time and
// turns it into the shared strobes and serial data for WIDTH shift-register
// lanes. Lane i holds bit i of every entry, and entry 0 is the top. The block
// also tracks the stack depth, sequences the multi-cycle ADD/SUB, and flags
// overflow and underflow.
//
// Handshake: a command transfers on a rising edge where op_valid && op_ready.
// op_ready is high only in IDLE. The command fields must be stable while
// op_valid is high. Dropping op_valid before the transfer is allowed.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   op_valid/op_ready command handshake
//   op, op_data       opcode (NOP,PUSH,POP,SWAP,DUP,ADD,SUB,CLEAR) and operand
//   top_q             current top entry read back from the lanes
//   lane_d            serial-in bit per lane
//   lane_en/lane_dir  shift strobe (1 = push, 0 = pop toward top)
//   lane_swp          swap entries 0 and 1
//   lane_rst          lane clear (reset held or CLEAR)
//   depth             entry count 0..DEPTH
//   carry             carry/borrow of the last ADD/SUB
//   err_underflow/err_overflow  one-cycle error pulses
//   dbg_state         current FSM state, for observation
module stack_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  input  logic [WIDTH-1:0] top_q,
  output logic [WIDTH-1:0] lane_d,
  output logic             lane_en,
  output logic             lane_dir,
  output logic             lane_swp,
  output logic             lane_rst,
  output logic [DW-1:0]    depth,
  output logic             carry,
  output logic             err_underflow,
  output logic             err_overflow,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_SWAP = 3'd3;
  localparam logic [2:0] OP_DUP  = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  localparam logic [DW-1:0] FULL = DW'(DEPTH);
  localparam logic [DW-1:0] ONE  = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CAPB   = 3'd2,
    S_POP2   = 3'd3,
    S_PUSHR  = 3'd4
  } state_t;

  state_t           state;
  logic             clr_q;
  logic             arith_q;  // SETTLE leads into CAPB instead of IDLE
  logic             sub_q;
  logic [WIDTH-1:0] a_q;      // old top (first pop)
  logic [WIDTH-1:0] b_q;      // old second entry
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic             empty;
  logic             lt2;
  logic             full;

  assign op_ready  = (state == S_IDLE);
  assign lane_rst  = ~rst_n | clr_q;
  assign dbg_state = state;

  assign empty = (depth == '0);
  assign lt2   = empty || (depth == ONE);
  assign full  = (depth == FULL);

  // The top bit of each extended result is the carry for ADD.
  // For SUB it is the borrow, which is set exactly when B < A.
  assign sum_w = {1'b0, b_q} + {1'b0, a_q};
  assign dif_w = {1'b0, b_q} - {1'b0, a_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lane_d        <= '0;
      lane_en       <= 1'b0;
      lane_dir      <= 1'b0;
      lane_swp      <= 1'b0;
      clr_q         <= 1'b0;
      depth         <= '0;
      carry         <= 1'b0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      arith_q       <= 1'b0;
      sub_q         <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
    end else begin
      // Every strobe is a one-cycle pulse unless it is re-issued below.
      lane_d        <= '0;
      lane_en       <= 1'b0;
      lane_dir      <= 1'b0;
      lane_swp      <= 1'b0;
      clr_q         <= 1'b0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            case (op)
              OP_NOP: ;
              OP_PUSH: begin
                if (full) err_overflow <= 1'b1;
                else begin
                  lane_en  <= 1'b1;
                  lane_dir <= 1'b1;
                  lane_d   <= op_data;
                  depth    <= depth + ONE;
                  state    <= S_SETTLE;
                end
              end
              OP_POP: begin
                if (empty) err_underflow <= 1'b1;
                else begin
                  lane_en <= 1'b1;
                  depth   <= depth - ONE;
                  state   <= S_SETTLE;
                end
              end
              OP_SWAP: begin
                if (lt2) err_underflow <= 1'b1;
                else begin
                  lane_swp <= 1'b1;
                  state    <= S_SETTLE;
                end
              end
              OP_DUP: begin
                if (empty) err_underflow <= 1'b1;
                else if (full) err_overflow <= 1'b1;
                else begin
                  lane_en  <= 1'b1;
                  lane_dir <= 1'b1;
                  lane_d   <= top_q;
                  depth    <= depth + ONE;
                  state    <= S_SETTLE;
                end
              end
              OP_ADD, OP_SUB: begin
                if (lt2) err_underflow <= 1'b1;
                else begin
                  // Net depth change for ADD/SUB is -1, applied here.
                  a_q     <= top_q;
                  sub_q   <= (op == OP_SUB);
                  arith_q <= 1'b1;
                  lane_en <= 1'b1;
                  depth   <= depth - ONE;
                  state   <= S_SETTLE;
                end
              end
              OP_CLR: begin
                clr_q <= 1'b1;
                depth <= '0;
                state <= S_SETTLE;
              end
              default: ;
            endcase
          end
        end
        S_SETTLE: begin
          // Lets the last strobe land before top_q is read again.
          if (arith_q) begin
            arith_q <= 1'b0;
            state   <= S_CAPB;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CAPB: begin
          b_q     <= top_q;
          lane_en <= 1'b1;
          state   <= S_POP2;
        end
        S_POP2: begin
          lane_en  <= 1'b1;
          lane_dir <= 1'b1;
          lane_d   <= sub_q ? dif_w[WIDTH-1:0] : sum_w[WIDTH-1:0];
          carry    <= sub_q ? dif_w[WIDTH] : sum_w[WIDTH];
          state    <= S_PUSHR;
        end
        S_PUSHR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int DW = $clog2(D + 1);

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] PUSH = 3'd1;
  localparam logic [2:0] POP  = 3'd2;
  localparam logic [2:0] SWAP = 3'd3;
  localparam logic [2:0] DUP  = 3'd4;
  localparam logic [2:0] ADD  = 3'd5;
  localparam logic [2:0] SUB  = 3'd6;
  localparam logic [2:0] CLR  = 3'd7;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  op_data = '0;
  logic          op_ready;
  logic [W-1:0]  top_q;
  logic [W-1:0]  lane_d;
  logic          lane_en, lane_dir, lane_swp, lane_rst;
  logic [DW-1:0] depth;
  logic          carry, err_underflow, err_overflow;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  stack_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_data(op_data),
    .op_ready(op_ready), .top_q(top_q), .lane_d(lane_d), .lane_en(lane_en),
    .lane_dir(lane_dir), .lane_swp(lane_swp), .lane_rst(lane_rst), .depth(depth),
    .carry(carry), .err_underflow(err_underflow), .err_overflow(err_overflow),
    .dbg_state(dbg_state)
  );

  // Behavioural stand-in for the lanes, kept as whole words (entry 0 = top).
  logic [W-1:0] mem [D];
  assign top_q = mem[0];

  always @(posedge clk) begin
    if (lane_rst) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (lane_en) begin
      if (lane_dir) begin
        for (int i = D - 1; i > 0; i--) mem[i] <= mem[i-1];
        mem[0] <= lane_d;
      end else begin
        for (int i = 0; i < D - 1; i++) mem[i] <= mem[i+1];
        mem[D-1] <= '0;
      end
    end else if (lane_swp) begin
      mem[0] <= mem[1];
      mem[1] <= mem[0];
    end
  end

  // Cycle counter and the cycle of the most recent accept.
  int cyc = 0;
  int acc_last = -1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (op_valid && op_ready) acc_last <= cyc;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] stk[$];   // front = top of stack
  logic [W-1:0] exp_q[$]; // values expected on pushes, in order
  bit           m_carry = 1'b0;
  int           checks = 0;
  int           errors = 0;

  function automatic bit mem_matches();
    bit ok = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (i < stk.size()) begin
        if (mem[i] !== stk[i]) ok = 1'b0;
      end else if (mem[i] !== '0) ok = 1'b0;
    end
    return ok;
  endfunction

  // Strobe code per cycle: 0 none, 1 push, 2 pop, 3 swap, 4 clear.
  function automatic int strobe_code();
    if (lane_rst) return 4;
    if (lane_swp) return 3;
    if (lane_en)  return lane_dir ? 1 : 2;
    return 0;
  endfunction

  // Drive one command and check the complete outcome against the model.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] dat, input string tag);
    int exp_seq[$];
    bit exp_uf, exp_of;
    int busy, uf_cnt, of_cnt, obs_code, exp_code, push_bad, code;
    bit both;
    logic [W-1:0] a, b, r, pd;
    int s;
    exp_uf = 0; exp_of = 0;
    case (o)
      PUSH: if (stk.size() == D) exp_of = 1;
            else begin stk.push_front(dat); exp_seq = '{1}; exp_q.push_back(dat); end
      POP:  if (stk.size() == 0) exp_uf = 1;
            else begin void'(stk.pop_front()); exp_seq = '{2}; end
      SWAP: if (stk.size() < 2) exp_uf = 1;
            else begin a = stk[0]; stk[0] = stk[1]; stk[1] = a; exp_seq = '{3}; end
      DUP:  if (stk.size() == 0) exp_uf = 1;
            else if (stk.size() == D) exp_of = 1;
            else begin stk.push_front(stk[0]); exp_seq = '{1}; exp_q.push_back(stk[0]); end
      ADD, SUB: if (stk.size() < 2) exp_uf = 1;
            else begin
              a = stk.pop_front();
              b = stk.pop_front();
              if (o == ADD) begin
                s = int'(b) + int'(a);
                r = W'(s);
                m_carry = (s >= (1 << W));
              end else begin
                r = b - a;
                m_carry = (b < a);
              end
              stk.push_front(r);
              exp_q.push_back(r);
              exp_seq = '{2, 0, 2, 1};
            end
      CLR:  begin stk.delete(); exp_seq = '{4}; end
      default: ;
    endcase

    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b want 1", tag, op_ready);
    end
    op_valid = 1'b1; op = o; op_data = dat;
    @(posedge clk); #1;
    op_valid = 1'b0; op = NOP; op_data = W'($urandom);

    busy = 0; uf_cnt = 0; of_cnt = 0; obs_code = 0; push_bad = 0; both = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      code = strobe_code();
      obs_code = obs_code * 8 + code;
      if (lane_en && lane_swp) both = 1;
      if (code == 1) begin
        pd = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (lane_d !== pd) push_bad++;
      end
      uf_cnt += int'(err_underflow);
      of_cnt += int'(err_overflow);
      if (op_ready) break;
      busy++;
    end
    exp_code = 0;
    foreach (exp_seq[i]) exp_code = exp_code * 8 + exp_seq[i];
    exp_code = exp_code * 8;
    exp_q.delete();

    checks++;
    if (obs_code !== exp_code) begin
      errors++;
      $display("FAIL %s strobe_seq: got %0o want %0o", tag, obs_code, exp_code);
    end
    checks++;
    if (busy !== exp_seq.size()) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy, exp_seq.size());
    end
    checks++;
    if (push_bad != 0) begin
      errors++;
      $display("FAIL %s push_data: %0d wrong lane_d values", tag, push_bad);
    end
    checks++;
    if (uf_cnt != int'(exp_uf) || of_cnt != int'(exp_of)) begin
      errors++;
      $display("FAIL %s err_pulses: got uf=%0d of=%0d want uf=%0d of=%0d",
               tag, uf_cnt, of_cnt, exp_uf, exp_of);
    end
    checks++;
    if (both) begin
      errors++;
      $display("FAIL %s en_swp_overlap: got 1 want 0", tag);
    end
    checks++;
    if (depth !== DW'(stk.size())) begin
      errors++;
      $display("FAIL %s depth: got %0d want %0d", tag, depth, stk.size());
    end
    checks++;
    if (carry !== m_carry) begin
      errors++;
      $display("FAIL %s carry: got %b want %b", tag, carry, m_carry);
    end
    checks++;
    if (!mem_matches()) begin
      errors++;
      $display("FAIL %s contents: top got %h want %h (depth %0d)", tag, mem[0],
               (stk.size() > 0) ? stk[0] : '0, stk.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (lane_rst !== 1'b1 || op_ready !== 1'b1 || depth !== '0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rst=%b rdy=%b depth=%0d carry=%b want 1 1 0 0",
               lane_rst, op_ready, depth, carry);
    end
    checks++;
    if ({lane_en, lane_dir, lane_swp, err_underflow, err_overflow} !== 5'b0 || lane_d !== '0) begin
      errors++;
      $display("FAIL reset_strobes: got %b d=%h want 00000 d=0",
               {lane_en, lane_dir, lane_swp, err_underflow, err_overflow}, lane_d);
    end
    stk.delete();
    m_carry = 1'b0;
    checks++;
    if (!mem_matches()) begin
      errors++;
      $display("FAIL reset_lanes: got top %h want all zero", mem[0]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    issue(PUSH, 4'd3, "add_push3");
    issue(PUSH, 4'd5, "add_push5");
    issue(ADD, 4'd0, "add_3_5");
    checks++;
    if (top_q !== 4'd8 || depth !== DW'(1) || carry !== 1'b0) begin
      errors++;
      $display("FAIL add_result: got top=%0d depth=%0d carry=%b want 8 1 0", top_q, depth, carry);
    end
  endtask

  task automatic test_sub_carry();
    issue(CLR, 4'd0, "sub_clear");
    issue(PUSH, 4'd2, "sub_push2");
    issue(PUSH, 4'd5, "sub_push5");
    issue(SUB, 4'd0, "sub_2_5");
    checks++;
    if (top_q !== 4'd13 || carry !== 1'b1) begin
      errors++;
      $display("FAIL sub_borrow: got top=%0d carry=%b want 13 1", top_q, carry);
    end
    issue(PUSH, 4'd15, "sub_push15");
    issue(ADD, 4'd0, "add_wrap");
    checks++;
    if (top_q !== 4'd12 || carry !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: got top=%0d carry=%b want 12 1", top_q, carry);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1;
    bit done;
    issue(CLR, 4'd0, "b2b_clear");
    @(negedge clk);
    op_valid = 1'b1; op = PUSH; op_data = 4'd7;
    @(posedge clk); #1;
    a0 = acc_last;
    op = DUP;
    a1 = a0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (acc_last != a0) begin a1 = acc_last; break; end
    end
    op_valid = 1'b0; op = NOP;
    stk.push_front(4'd7);
    stk.push_front(4'd7);
    checks++;
    if (a1 - a0 != 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want 2", a1 - a0);
    end
    done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (op_ready) begin done = 1; break; end
    end
    checks++;
    if (!done || depth !== DW'(2) || !mem_matches()) begin
      errors++;
      $display("FAIL b2b_state: got ready=%b depth=%0d top=%h,%h want 1 2 7,7",
               done, depth, mem[0], mem[1]);
    end
  endtask

  task automatic test_errors();
    issue(CLR, 4'd0, "err_clear");
    issue(POP, 4'd0, "err_pop_empty");
    issue(SWAP, 4'd0, "err_swap_empty");
    issue(DUP, 4'd0, "err_dup_empty");
    issue(PUSH, 4'd9, "err_push1");
    issue(ADD, 4'd0, "err_add_one");
    for (int i = 1; i < D; i++) issue(PUSH, W'($urandom), "err_fill");
    issue(PUSH, 4'd1, "err_push_full");
    issue(DUP, 4'd0, "err_dup_full");
    checks++;
    if (depth !== DW'(D)) begin
      errors++;
      $display("FAIL full_depth: got %0d want %0d", depth, D);
    end
  endtask

  task automatic test_reset_mid_add();
    bit stray;
    issue(CLR, 4'd0, "rst_clear");
    issue(PUSH, 4'd4, "rst_push4");
    issue(PUSH, 4'd6, "rst_push6");
    @(negedge clk);
    op_valid = 1'b1; op = ADD;
    @(posedge clk); #1;        // E0
    op_valid = 1'b0; op = NOP;
    @(posedge clk); #1;        // E1
    rst_n = 1'b0;              // sampled at E2 and E3
    stray = 0;
    @(negedge clk);            // window E1-E2
    @(negedge clk);            // window E2-E3
    if (lane_en || lane_swp) stray = 1;
    @(negedge clk);            // window E3-E4
    if (lane_en || lane_swp) stray = 1;
    rst_n = 1'b1;
    @(negedge clk);            // window E4-E5
    if (lane_en || lane_swp) stray = 1;
    stk.delete();
    m_carry = 1'b0;
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL rst_mid_strobes: got strobe after reset want none");
    end
    checks++;
    if (op_ready !== 1'b1 || depth !== '0 || carry !== 1'b0 || lane_rst !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: got rdy=%b depth=%0d carry=%b rst=%b want 1 0 0 0",
               op_ready, depth, carry, lane_rst);
    end
    checks++;
    if (!mem_matches()) begin
      errors++;
      $display("FAIL rst_mid_lanes: got top %h want all zero", mem[0]);
    end
  endtask

  task automatic test_random();
    int r;
    logic [2:0] o;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 30) o = PUSH;
      else if (r < 45) o = POP;
      else if (r < 55) o = SWAP;
      else if (r < 65) o = DUP;
      else if (r < 76) o = ADD;
      else if (r < 87) o = SUB;
      else if (r < 92) o = CLR;
      else o = NOP;
      issue(o, W'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_carry();
    test_back_to_back();
    test_errors();
    test_reset_mid_add();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
